dpram_port_arbiter: RTL

//  Shares one synchronous-read port of dual_port_ram (clk/we/addr/data_in/data_out)

---
 rtl/dpram_port_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter that shares one synchronous-read RAM port between
// NUM_REQ requesters. Requests are accepted with a valid/ready handshake.
// One access issues per cycle, and every access (read or write) gets a
// response strobe two cycles after it is accepted.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   req_valid/req_ready per-requester request handshake (ready is one-hot or zero)
//   req_we              per-requester write enable (1=write, 0=read)
//   req_addr/req_wdata  flat per-requester address / write data
//   rsp_valid           per-requester response strobe (one-hot or zero)
//   rsp_rdata           read data for the strobed requester (old word on writes)
//   ram_we/ram_addr/ram_wdata  registered RAM port controls
//   ram_rdata           RAM read data (registered inside the RAM, 1-cycle)
module dpram_port_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [ID_W-1:0] id_t;

  id_t                   rr_ptr_q,    rr_ptr_d;
  logic                  ram_we_q,    ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  s1_vld_q,    s1_vld_d;
  id_t                   s1_id_q,     s1_id_d;
  logic                  s2_vld_q,    s2_vld_d;
  id_t                   s2_id_q,     s2_id_d;

  logic                  grant_vld;
  id_t                   grant_id;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin : p_arb
    int unsigned cand;
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_vld && req_valid[id_t'(cand)]) begin
        grant_vld = 1'b1;
        grant_id  = id_t'(cand);
      end
    end
  end

  // Select the granted requester's payload
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == id_t'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready is gated by rst_n so nothing is handshaken while reset is held
  always_comb begin
    req_ready = '0;
    if (grant_vld && rst_n) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Next-state: pointer advance, issue stage, and response pipeline
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    s1_vld_d    = grant_vld;
    s1_id_d     = grant_id;
    s2_vld_d    = s1_vld_q;
    s2_id_d     = s1_id_q;
    if (grant_vld) begin
      rr_ptr_d    = (grant_id == id_t'(NUM_REQ - 1)) ? '0 : grant_id + id_t'(1);
      ram_we_d    = sel_we;
      ram_addr_d  = sel_addr;
      ram_wdata_d = sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      s1_vld_q    <= 1'b0;
      s1_id_q     <= '0;
      s2_vld_q    <= 1'b0;
      s2_id_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      s1_vld_q    <= s1_vld_d;
      s1_id_q     <= s1_id_d;
      s2_vld_q    <= s2_vld_d;
      s2_id_q     <= s2_id_d;
    end
  end

  // Response: RAM data lines up with the stage-2 tag
  always_comb begin
    rsp_valid = '0;
    if (s2_vld_q) begin
      rsp_valid[s2_id_q] = 1'b1;
    end
    rsp_rdata = ram_rdata;
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
